axis_rr_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI-Stream master port between NUM_IN AXI-Stream slave requesters. It sits in front of a shared stream resource such as a register slice or the mlp-controller downstream path, and grants one requester at a time. A grant stays locked until that requester's TLAST beat is accepted, so packets are never interleaved. The output is registered, with full valid/ready backpressure and no combinational path from the master TREADY to the master TVALID.

---
 rtl/axis_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one registered
// AXI-Stream master port between NUM_IN requesters. A grant is held until the
// granted requester's TLAST beat is accepted, so packets never interleave.
// Optional macro AXIS_ARB_SRC_TAG_EN: replace the outgoing TID with the
// granted source index (zero-extended to IDW).
module axis_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATAW  = 32,
  parameter int IDW    = 4,
  parameter int USERW  = 4,
  parameter int DESTW  = 4,
  localparam int IDXW  = $clog2(NUM_IN)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_IN-1:0]         AXIS_S_TVALID,
  output logic [NUM_IN-1:0]         AXIS_S_TREADY,
  input  logic [NUM_IN*DATAW-1:0]   AXIS_S_TDATA,
  input  logic [NUM_IN-1:0]         AXIS_S_TLAST,
  input  logic [NUM_IN*IDW-1:0]     AXIS_S_TID,
  input  logic [NUM_IN*USERW-1:0]   AXIS_S_TUSER,
  input  logic [NUM_IN*DESTW-1:0]   AXIS_S_TDEST,
  output logic                      AXIS_M_TVALID,
  input  logic                      AXIS_M_TREADY,
  output logic [DATAW-1:0]          AXIS_M_TDATA,
  output logic                      AXIS_M_TLAST,
  output logic [IDW-1:0]            AXIS_M_TID,
  output logic [USERW-1:0]          AXIS_M_TUSER,
  output logic [DESTW-1:0]          AXIS_M_TDEST,
  output logic                      GRANT_ACTIVE,
  output logic [IDXW-1:0]           GRANT_IDX
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;
  localparam logic [IDXW:0] NUM_IN_W = (IDXW+1)'(NUM_IN);

  logic [0:0]       state_reg;
  logic [IDXW-1:0]  ptr_reg;
  logic [IDXW-1:0]  grant_idx_reg;

  logic             m_tvalid_reg;
  logic [DATAW-1:0] m_tdata_reg;
  logic             m_tlast_reg;
  logic [IDW-1:0]   m_tid_reg;
  logic [USERW-1:0] m_tuser_reg;
  logic [DESTW-1:0] m_tdest_reg;

  // Per-requester views of the flattened sideband buses
  logic [DATAW-1:0] s_tdata_arr [NUM_IN];
  logic [IDW-1:0]   s_tid_arr   [NUM_IN];
  logic [USERW-1:0] s_tuser_arr [NUM_IN];
  logic [DESTW-1:0] s_tdest_arr [NUM_IN];

  logic             slot_open;
  logic             accept;
  logic             grant_last;
  logic [IDXW-1:0]  ptr_wrap;
  logic [IDW-1:0]   tid_load;
  logic             sel_found;
  logic [IDXW-1:0]  sel_idx;

  // The output slot can take a beat when empty or being drained this cycle
  assign slot_open  = (state_reg == ST_PASS) && (!m_tvalid_reg || AXIS_M_TREADY);
  assign accept     = slot_open && AXIS_S_TVALID[grant_idx_reg];
  assign grant_last = AXIS_S_TLAST[grant_idx_reg];
  assign ptr_wrap   = (grant_idx_reg == IDXW'(NUM_IN-1)) ? '0 : grant_idx_reg + IDXW'(1);

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign s_tdata_arr[gi]   = AXIS_S_TDATA[gi*DATAW +: DATAW];
      assign s_tid_arr[gi]     = AXIS_S_TID[gi*IDW +: IDW];
      assign s_tuser_arr[gi]   = AXIS_S_TUSER[gi*USERW +: USERW];
      assign s_tdest_arr[gi]   = AXIS_S_TDEST[gi*DESTW +: DESTW];
      assign AXIS_S_TREADY[gi] = slot_open && (grant_idx_reg == IDXW'(gi));
    end
  endgenerate

`ifdef AXIS_ARB_SRC_TAG_EN
  assign tid_load = IDW'(grant_idx_reg);
`else
  assign tid_load = s_tid_arr[grant_idx_reg];
`endif

  // Rotating-priority search: first valid requester at PTR, PTR+1, ... (mod NUM_IN)
  always_comb begin
    logic [IDXW:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    // Walk from the farthest offset down so the nearest valid requester wins
    for (int k = NUM_IN-1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDXW+1)'(k);
      if (cand >= NUM_IN_W) cand = cand - NUM_IN_W;
      if (AXIS_S_TVALID[cand[IDXW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDXW-1:0];
      end
    end
  end

  // Grant FSM: lock a requester in ARB, release and rotate PTR at its TLAST
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_ARB;
      ptr_reg       <= '0;
      grant_idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_ARB: begin
          if (sel_found) begin
            grant_idx_reg <= sel_idx;
            state_reg     <= ST_PASS;
          end
        end
        default: begin
          if (accept && grant_last) begin
            ptr_reg   <= ptr_wrap;
            state_reg <= ST_ARB;
          end
        end
      endcase
    end
  end

  // Output register: load on accept, otherwise drain when the master takes the beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_tid_reg    <= '0;
      m_tuser_reg  <= '0;
      m_tdest_reg  <= '0;
    end else if (accept) begin
      m_tvalid_reg <= 1'b1;
      m_tdata_reg  <= s_tdata_arr[grant_idx_reg];
      m_tlast_reg  <= grant_last;
      m_tid_reg    <= tid_load;
      m_tuser_reg  <= s_tuser_arr[grant_idx_reg];
      m_tdest_reg  <= s_tdest_arr[grant_idx_reg];
    end else if (AXIS_M_TREADY) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  assign AXIS_M_TVALID = m_tvalid_reg;
  assign AXIS_M_TDATA  = m_tdata_reg;
  assign AXIS_M_TLAST  = m_tlast_reg;
  assign AXIS_M_TID    = m_tid_reg;
  assign AXIS_M_TUSER  = m_tuser_reg;
  assign AXIS_M_TDEST  = m_tdest_reg;
  assign GRANT_ACTIVE  = (state_reg == ST_PASS);
  assign GRANT_IDX     = grant_idx_reg;

endmodule
